pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Per-core pipeline sequencing controller for the 5-stage datapath. It drives the update-enable and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB latches. It resolves icache misses, dcache stalls, load-use hazards, control-flow redirects and halt draining into one consistent set of latch commands per cycle. It also keeps a small set of stall/flush performance counters.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter (saturating)

Ports:
- CLK  in  1  core clock
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  icache returned the instruction for the current PC this cycle
- dhit  in  1  dcache completed the MEM-stage access this cycle
- mem_dREN, mem_dWEN  in  1 each  EX/MEM latch memory read/write request
- ex_dREN  in  1  ID/EX latch dREN_o (instruction in EX is a load)
- ex_regWr  in  1  ID/EX latch regWr_o
- ex_wsel  in  5  destination register of the EX instruction
- id_rs, id_rt  in  5 each  source registers of the ID instruction
- id_uses_rt  in  1  ID instruction reads rt
- ex_redirect  in  1  EX resolved a taken branch/jump; the PC mux selects the target
- wb_halt  in  1  MEM/WB latch halt_o
- pc_en  out  1  PC register load enable
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch update enable
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  latch flush (bubble insert)
- halt  out  1  sticky core-halted indication
- stall_cycles, flush_events  out  CNT_W each  performance counters

## Operation
- Each latch's freeze input is tied to !en at the top level, so freeze is never a separate output.
- FSM states: RUN, MEMWAIT, HALTED. Reset state is RUN.
- mem_req = mem_dREN | mem_dWEN.
- load_use = ex_dREN & ex_regWr & (ex_wsel != 0) & (ex_wsel == id_rs | (id_uses_rt & ex_wsel == id_rt)).
- Priority, highest first:
  1. HALTED: all en = 0, all flush = 0.
  2. Memory stall (mem_req & !dhit): all en = 0, all flush = 0. Redirect and load-use are ignored because the EX instruction is retained and re-evaluated.
  3. ex_redirect: pc_en = 1, idex_flush = 1, and ifid_flush = 1. All other latches are enabled. A load_use hazard in the same cycle is squashed.
  4. load_use: pc_en = 0, ifid_en = 0, idex_flush = 1. EX/MEM and MEM/WB are enabled.
  5. !ihit: pc_en = 0, ifid_flush = 1. All other latches are enabled.
  6. Otherwise all en = 1 and all flush = 0.
- Transitions:
  - RUN → MEMWAIT when mem_req & !dhit.
  - MEMWAIT → RUN on dhit.
  - Any state → HALTED when wb_halt is sampled at 1 and the pipeline is not memory-stalled. The MEM/WB instruction is allowed to write back in that same cycle.
  - HALTED is exited only by reset.
- halt = (state == HALTED). It is registered and asserts the cycle after wb_halt is accepted.
- stall_cycles increments in every cycle with pc_en = 0 while not HALTED.
- flush_events increments once per cycle in which any flush is 1.
- Both counters saturate at 2^CNT_W − 1.
- While nRST = 0, every en and flush output is 0. State, halt and the counters are cleared.

## Timing
- All en/flush outputs are combinational from state and inputs, within the same cycle.
- halt and the counters are registered, with a one-cycle latency.
- Memory stall of N cycles: exactly N cycles with all en = 0. The dhit cycle enables all latches.
- Load-use costs exactly one bubble cycle. Redirect costs two squashed slots, both in the same cycle.
- Reset may be asserted mid-MEMWAIT. In that case the state returns to RUN immediately and no residual stall is held.
- Simultaneous mem stall and !ihit: the mem stall wins and ifid_flush = 0, so the fetched instruction is not lost.

## Structure
- Add to cpu_types_pkg:
  - pctrl_state_t enum {RUN, MEMWAIT, HALTED}
  - the regbits_t 5-bit type, if not already present
- Add sub-module hazard_detect (combinational load_use and priority decode) feeding a registered FSM/counter top.
- Add a pipeline_ctrl_if interface with modports pctrl and tb.

## Test plan
- ex_dREN=1, ex_regWr=1, ex_wsel=5, id_rs=5, ihit=1, dhit=1 → pc_en=0, ifid_en=0, idex_flush=1 for one cycle; stall_cycles goes 0→1.
- Same hazard but ex_wsel=0 → no stall; all en=1.
- mem_dREN=1, dhit low for 3 cycles then high → 3 cycles of all en=0, then all en=1; state returns to RUN.
- ex_redirect=1 together with load_use → pc_en=1, ifid_flush=1, idex_flush=1; flush_events +1.
- ex_redirect=1 during a dcache stall → all en=0 until dhit, then the redirect is applied.
- wb_halt=1 → halt=1 next cycle, all en=0 forever; nRST pulse → halt=0 and counters=0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the per-core pipeline sequencing controller:
// FSM state encoding, register index type and the per-cycle latch command bundle.
package pipeline_ctrl_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALTED  = 2'd2
    } pctrl_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic memwb_flush;
    } pctrl_cmd_t;

    // Everything frozen, nothing flushed.
    localparam pctrl_cmd_t CMD_HOLD = '{default: 1'b0};

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline datapath and its sequencing controller.
interface pipeline_ctrl_if
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic             ihit;
    logic             dhit;
    logic             mem_dREN;
    logic             mem_dWEN;
    logic             ex_dREN;
    logic             ex_regWr;
    regbits_t         ex_wsel;
    regbits_t         id_rs;
    regbits_t         id_rt;
    logic             id_uses_rt;
    logic             ex_redirect;
    logic             wb_halt;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             memwb_flush;
    logic             halt;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport pctrl (
        input  ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_regWr, ex_wsel,
               id_rs, id_rt, id_uses_rt, ex_redirect, wb_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               halt, stall_cycles, flush_events
    );

    modport tb (
        output ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_regWr, ex_wsel,
               id_rs, id_rt, id_uses_rt, ex_redirect, wb_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               halt, stall_cycles, flush_events
    );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational hazard detection and priority decode into one latch command per cycle.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic       blocked,
    input  logic       ihit,
    input  logic       dhit,
    input  logic       mem_dREN,
    input  logic       mem_dWEN,
    input  logic       ex_dREN,
    input  logic       ex_regWr,
    input  regbits_t   ex_wsel,
    input  regbits_t   id_rs,
    input  regbits_t   id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_redirect,
    output logic       mem_stall,
    output pctrl_cmd_t cmd
);
    logic load_use_s;

    // Priority decode: halt/reset, memory stall, redirect, load-use, icache miss, run.
    always_comb begin
        mem_stall  = (mem_dREN | mem_dWEN) & ~dhit;
        load_use_s = ex_dREN & ex_regWr & (ex_wsel != 5'd0) &
                     ((ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt)));
        cmd = CMD_HOLD;
        if (blocked) begin
            cmd = CMD_HOLD;
        end else if (mem_stall) begin
            // EX instruction is retained, so redirect/load-use re-resolve after dhit.
            cmd = CMD_HOLD;
        end else if (ex_redirect) begin
            cmd = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1,
                    memwb_en: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1,
                    exmem_flush: 1'b0, memwb_flush: 1'b0};
        end else if (load_use_s) begin
            cmd = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b1, exmem_en: 1'b1,
                    memwb_en: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b1,
                    exmem_flush: 1'b0, memwb_flush: 1'b0};
        end else if (!ihit) begin
            cmd = '{pc_en: 1'b0, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1,
                    memwb_en: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b0,
                    exmem_flush: 1'b0, memwb_flush: 1'b0};
        end else begin
            cmd = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1,
                    memwb_en: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0,
                    exmem_flush: 1'b0, memwb_flush: 1'b0};
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: RUN/MEMWAIT/HALTED FSM, latch command outputs
// and saturating stall/flush performance counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
)(
    input logic            CLK,
    input logic            nRST,
    pipeline_ctrl_if.pctrl bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    pctrl_state_t     state_r;
    pctrl_cmd_t       cmd_s;
    logic             mem_stall_s;
    logic             blocked_s;
    logic             any_flush_s;
    logic [CNT_W-1:0] stall_r;
    logic [CNT_W-1:0] flush_r;

    // Reset drives every command low, independent of the clock.
    assign blocked_s   = ~nRST | (state_r == HALTED);
    assign any_flush_s = cmd_s.ifid_flush | cmd_s.idex_flush |
                         cmd_s.exmem_flush | cmd_s.memwb_flush;

    hazard_detect u_hazard (
        .blocked     (blocked_s),
        .ihit        (bus.ihit),
        .dhit        (bus.dhit),
        .mem_dREN    (bus.mem_dREN),
        .mem_dWEN    (bus.mem_dWEN),
        .ex_dREN     (bus.ex_dREN),
        .ex_regWr    (bus.ex_regWr),
        .ex_wsel     (bus.ex_wsel),
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .id_uses_rt  (bus.id_uses_rt),
        .ex_redirect (bus.ex_redirect),
        .mem_stall   (mem_stall_s),
        .cmd         (cmd_s)
    );

    // Sequencing FSM; a halt is accepted only once the MEM stage is not stalled.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= RUN;
        end else begin
            case (state_r)
                RUN: begin
                    if (bus.wb_halt && !mem_stall_s) state_r <= HALTED;
                    else if (mem_stall_s)            state_r <= MEMWAIT;
                    else                             state_r <= RUN;
                end
                MEMWAIT: begin
                    if (bus.wb_halt && !mem_stall_s) state_r <= HALTED;
                    else if (bus.dhit)               state_r <= RUN;
                    else                             state_r <= MEMWAIT;
                end
                HALTED:  state_r <= HALTED;
                default: state_r <= RUN;
            endcase
        end
    end

    // Saturating performance counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_r <= {CNT_W{1'b0}};
            flush_r <= {CNT_W{1'b0}};
        end else begin
            if (!cmd_s.pc_en && (state_r != HALTED)) stall_r <= sat_inc(stall_r);
            else                                     stall_r <= stall_r;
            if (any_flush_s) flush_r <= sat_inc(flush_r);
            else             flush_r <= flush_r;
        end
    end

    assign bus.pc_en        = cmd_s.pc_en;
    assign bus.ifid_en      = cmd_s.ifid_en;
    assign bus.idex_en      = cmd_s.idex_en;
    assign bus.exmem_en     = cmd_s.exmem_en;
    assign bus.memwb_en     = cmd_s.memwb_en;
    assign bus.ifid_flush   = cmd_s.ifid_flush;
    assign bus.idex_flush   = cmd_s.idex_flush;
    assign bus.exmem_flush  = cmd_s.exmem_flush;
    assign bus.memwb_flush  = cmd_s.memwb_flush;
    assign bus.halt         = (state_r == HALTED);
    assign bus.stall_cycles = stall_r;
    assign bus.flush_events = flush_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a rule-level model is compared every cycle,
// plus literal checkpoints on the counters and halt.
module tb_pipeline_ctrl;
    localparam int CNT_W   = 4;
    localparam int CNT_TOP = (1 << CNT_W) - 1;

    logic CLK;
    logic nRST;
    int   errors;
    int   checks;

    // model state
    bit halted_m;
    int stall_m;
    int flush_m;

    pipeline_ctrl_if #(.CNT_W(CNT_W)) pif ();

    pipeline_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (pif.pctrl)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // {pc, ifid, idex, exmem, memwb, f_ifid, f_idex, f_exmem, f_memwb}
    function automatic logic [8:0] exp_cmd();
        bit stall, lu;
        stall = (pif.mem_dREN || pif.mem_dWEN) && !pif.dhit;
        lu = pif.ex_dREN && pif.ex_regWr && (pif.ex_wsel != 5'd0) &&
             ((pif.ex_wsel == pif.id_rs) || (pif.id_uses_rt && (pif.ex_wsel == pif.id_rt)));
        if (!nRST || halted_m)  return 9'b00000_0000;
        if (stall)              return 9'b00000_0000;
        if (pif.ex_redirect)    return 9'b11111_1100;
        if (lu)                 return 9'b00111_0100;
        if (!pif.ihit)          return 9'b01111_1000;
        return 9'b11111_0000;
    endfunction

    task automatic set_idle();
        pif.ihit = 1'b1; pif.dhit = 1'b1;
        pif.mem_dREN = 1'b0; pif.mem_dWEN = 1'b0;
        pif.ex_dREN = 1'b0; pif.ex_regWr = 1'b0; pif.ex_wsel = 5'd0;
        pif.id_rs = 5'd0; pif.id_rt = 5'd0; pif.id_uses_rt = 1'b0;
        pif.ex_redirect = 1'b0; pif.wb_halt = 1'b0;
    endtask

    // One cycle: compare at negedge, advance the model at posedge, return 1 time unit later.
    task automatic tick(input int n = 1);
        logic [8:0] e, a;
        bit stall, nxt_halt;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (!nRST) begin
                halted_m = 1'b0; stall_m = 0; flush_m = 0;
            end
            e = exp_cmd();
            a = {pif.pc_en, pif.ifid_en, pif.idex_en, pif.exmem_en, pif.memwb_en,
                 pif.ifid_flush, pif.idex_flush, pif.exmem_flush, pif.memwb_flush};
            check("cmd", {23'd0, a}, {23'd0, e});
            check("halt", {31'd0, pif.halt}, {31'd0, halted_m});
            check("stall_cycles", {28'd0, pif.stall_cycles}, stall_m);
            check("flush_events", {28'd0, pif.flush_events}, flush_m);
            stall    = (pif.mem_dREN || pif.mem_dWEN) && !pif.dhit;
            nxt_halt = halted_m || (pif.wb_halt && !stall);
            @(posedge CLK);
            if (!nRST) begin
                halted_m = 1'b0; stall_m = 0; flush_m = 0;
            end else begin
                if (!e[8] && !halted_m && stall_m < CNT_TOP) stall_m++;
                if (e[3:0] != 4'd0 && flush_m < CNT_TOP) flush_m++;
                halted_m = nxt_halt;
            end
            #1;
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        halted_m = 1'b0; stall_m = 0; flush_m = 0;
        set_idle();
        nRST = 1'b0;
        tick(2);
        check("reset_halt", {31'd0, pif.halt}, 32'd0);
        check("reset_stall", {28'd0, pif.stall_cycles}, 32'd0);
        nRST = 1'b1;
        tick(2);

        // load-use on rs: one bubble
        pif.ex_dREN = 1'b1; pif.ex_regWr = 1'b1; pif.ex_wsel = 5'd5; pif.id_rs = 5'd5;
        tick();
        check("lu_stall_pin", stall_m, 32'd1);
        check("lu_stall_dut", {28'd0, pif.stall_cycles}, 32'd1);
        // r0 destination never hazards
        pif.ex_wsel = 5'd0; pif.id_rs = 5'd0;
        tick();
        // rt hazard only when rt is used
        pif.ex_wsel = 5'd7; pif.id_rs = 5'd3; pif.id_rt = 5'd7; pif.id_uses_rt = 1'b1;
        tick();
        pif.id_uses_rt = 1'b0;
        tick();
        pif.id_uses_rt = 1'b1; pif.ex_regWr = 1'b0;
        tick();
        check("lu_flush_pin", flush_m, 32'd2);
        set_idle();

        // 3-cycle dcache stall, then dhit
        pif.mem_dREN = 1'b1; pif.dhit = 1'b0;
        tick(3);
        pif.dhit = 1'b1;
        tick();
        check("memstall_pin", stall_m, 32'd5);
        set_idle();

        // redirect squashes a simultaneous load-use
        pif.ex_dREN = 1'b1; pif.ex_regWr = 1'b1; pif.ex_wsel = 5'd9; pif.id_rs = 5'd9;
        pif.ex_redirect = 1'b1;
        tick();
        check("redirect_flush_pin", flush_m, 32'd3);
        check("redirect_flush_dut", {28'd0, pif.flush_events}, 32'd3);
        set_idle();

        // icache miss, then icache miss under dcache stall
        pif.ihit = 1'b0;
        tick();
        pif.mem_dWEN = 1'b1; pif.dhit = 1'b0;
        tick();
        check("imiss_pin", {stall_m[15:0], flush_m[15:0]}, {16'd7, 16'd4});
        set_idle();

        // redirect held behind a dcache stall, applied on dhit
        pif.mem_dWEN = 1'b1; pif.dhit = 1'b0; pif.ex_redirect = 1'b1;
        tick(2);
        pif.dhit = 1'b1;
        tick();
        check("redir_stall_pin", {stall_m[15:0], flush_m[15:0]}, {16'd9, 16'd5});
        set_idle();

        // counters saturate
        pif.ihit = 1'b0;
        tick(12);
        check("sat_pin", {stall_m[15:0], flush_m[15:0]}, {16'd15, 16'd15});
        check("sat_dut", {24'd0, pif.stall_cycles, pif.flush_events}, 32'hFF);
        set_idle();

        // halt refused while memory-stalled, accepted on dhit
        pif.wb_halt = 1'b1; pif.mem_dREN = 1'b1; pif.dhit = 1'b0;
        tick();
        check("halt_deferred", {31'd0, pif.halt}, 32'd0);
        pif.dhit = 1'b1;
        tick();
        check("halt_set", {31'd0, pif.halt}, 32'd1);
        set_idle();
        pif.ex_redirect = 1'b1; pif.ihit = 1'b0;
        tick(3);
        check("halted_pc_en", {31'd0, pif.pc_en}, 32'd0);
        set_idle();

        nRST = 1'b0;
        tick();
        check("rst_halt", {31'd0, pif.halt}, 32'd0);
        check("rst_cnt", {24'd0, pif.stall_cycles, pif.flush_events}, 32'd0);
        nRST = 1'b1;
        pif.ihit = 1'b0;
        tick();
        check("post_rst_pin", {stall_m[15:0], flush_m[15:0]}, {16'd1, 16'd1});
        set_idle();

        // reset in the middle of a dcache stall leaves no residual stall
        pif.mem_dREN = 1'b1; pif.dhit = 1'b0;
        tick(2);
        nRST = 1'b0;
        set_idle();
        tick();
        nRST = 1'b1;
        tick();
        check("rst_memwait_pc_en", {31'd0, pif.pc_en}, 32'd1);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
